// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: DREQ synchroniser, fixed/rotating channel arbitration
// and grant lock/release for an 8237A-style DMA controller.
module dma_priority_arbiter #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     commandReg,
  input  logic [NCH-1:0] maskReg,
  input  logic [NCH-1:0] requestReg,
  input  logic           IDLE_CYCLE,
  input  logic           validDACK,
  input  logic           EOP_N,
  output logic [NCH-1:0] VALID_DREQ,
  output logic           grantValid,
  output logic [1:0]     grantChannel,
  output logic [NCH-1:0] DACK,
  output logic [NCH-1:0] reqClear
);

  typedef enum logic {
    ST_ARB,
    ST_GRANT
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] dreqSync_q;
  logic [NCH-1:0] vdreq_q, vdreq_d;
  logic [1:0]     gch_q, gch_d;
  logic [1:0]     lowPri_q, lowPri_d;
  logic           eopSeen_q, eopSeen_d;
  logic [NCH-1:0] reqClear_q, reqClear_d;

  logic [NCH-1:0] req;
  logic [NCH-1:0] win;
  logic [1:0]     idx;
  logic [1:0]     vdEnc;
  logic [NCH-1:0] dackAct;
  logic           unused_cmd;

  assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  always_comb begin
    req = ((dreqSync_q ^ {NCH{commandReg[6]}}) & ~maskReg) | requestReg;
    if (commandReg[2]) req = '0;
  end

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = commandReg[4] ? lowPri_q + 2'(k + 1) : 2'(k);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    vdEnc = 2'd0;
    unique case (1'b1)
      vdreq_q[0]: vdEnc = 2'd0;
      vdreq_q[1]: vdEnc = 2'd1;
      vdreq_q[2]: vdEnc = 2'd2;
      vdreq_q[3]: vdEnc = 2'd3;
      default:    vdEnc = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    vdreq_d    = vdreq_q;
    gch_d      = gch_q;
    lowPri_d   = lowPri_q;
    eopSeen_d  = eopSeen_q;
    reqClear_d = '0;
    unique case (state_q)
      ST_ARB: begin
        if (IDLE_CYCLE) begin
          vdreq_d = win;
        end else if (|vdreq_q) begin
          state_d   = ST_GRANT;
          gch_d     = vdEnc;
          eopSeen_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!EOP_N) eopSeen_d = 1'b1;
        if (IDLE_CYCLE) begin
          state_d   = ST_ARB;
          vdreq_d   = '0;
          eopSeen_d = 1'b0;
          if (commandReg[4]) lowPri_d = gch_q;
          if (eopSeen_q || !EOP_N) reqClear_d[gch_q] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_ARB;
      dreqSync_q <= '0;
      vdreq_q    <= '0;
      gch_q      <= 2'd0;
      lowPri_q   <= 2'd3;
      eopSeen_q  <= 1'b0;
      reqClear_q <= '0;
    end else begin
      state_q    <= state_d;
      dreqSync_q <= DREQ;
      vdreq_q    <= vdreq_d;
      gch_q      <= gch_d;
      lowPri_q   <= lowPri_d;
      eopSeen_q  <= eopSeen_d;
      reqClear_q <= reqClear_d;
    end
  end

  assign VALID_DREQ   = vdreq_q;
  assign grantValid   = (state_q == ST_GRANT);
  assign grantChannel = gch_q;
  assign reqClear     = reqClear_q;

  always_comb begin
    dackAct = '0;
    if (grantValid && validDACK) dackAct[gch_q] = 1'b1;
    DACK = dackAct ^ {NCH{~commandReg[7]}};
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic [7:0] commandReg = '0;
  logic [3:0] maskReg = '0;
  logic [3:0] requestReg = '0;
  logic       IDLE_CYCLE = 1'b1;
  logic       validDACK = 1'b0;
  logic       EOP_N = 1'b1;
  logic [3:0] VALID_DREQ;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [3:0] DACK;
  logic [3:0] reqClear;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dma_priority_arbiter #(.NCH(4)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .DREQ         (DREQ),
    .commandReg   (commandReg),
    .maskReg      (maskReg),
    .requestReg   (requestReg),
    .IDLE_CYCLE   (IDLE_CYCLE),
    .validDACK    (validDACK),
    .EOP_N        (EOP_N),
    .VALID_DREQ   (VALID_DREQ),
    .grantValid   (grantValid),
    .grantChannel (grantChannel),
    .DACK         (DACK),
    .reqClear     (reqClear)
  );

  // Behavioural reference state
  logic [3:0] m_sync = '0;
  logic [3:0] m_vd = '0;
  logic [3:0] m_rc = '0;
  bit         m_gv = 1'b0;
  bit         m_eop = 1'b0;
  int         m_gc = 0;
  int         m_lp = 3;

  function automatic logic [3:0] pick(logic [3:0] r, bit rot, int lp);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = rot ? (lp + 1 + k) % 4 : k;
      if (r[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_dack();
    logic [3:0] a;
    a = '0;
    if (m_gv && validDACK) a[m_gc] = 1'b1;
    return commandReg[7] ? a : ~a;
  endfunction

  always @(posedge CLK) begin : model
    logic [3:0] r, n_vd, n_rc;
    bit n_gv, n_eop;
    int n_gc, n_lp;
    if (!RESET_N) begin
      m_sync = '0; m_vd = '0; m_rc = '0;
      m_gv = 0; m_eop = 0; m_gc = 0; m_lp = 3;
    end else begin
      r = ((m_sync ^ {4{commandReg[6]}}) & ~maskReg) | requestReg;
      if (commandReg[2]) r = '0;
      n_vd = m_vd; n_gv = m_gv; n_eop = m_eop;
      n_gc = m_gc; n_lp = m_lp; n_rc = '0;
      if (!m_gv) begin
        if (IDLE_CYCLE) n_vd = pick(r, commandReg[4], m_lp);
        else if (m_vd != 0) begin
          n_gv = 1; n_eop = 0;
          for (int k = 0; k < 4; k++) if (m_vd[k]) n_gc = k;
        end
      end else begin
        if (!EOP_N) n_eop = 1;
        if (IDLE_CYCLE) begin
          n_gv = 0; n_vd = '0; n_eop = 0;
          if (commandReg[4]) n_lp = m_gc;
          if (m_eop || !EOP_N) n_rc = 4'(1 << m_gc);
        end
      end
      m_sync = DREQ; m_vd = n_vd; m_gv = n_gv; m_eop = n_eop;
      m_gc = n_gc; m_lp = n_lp; m_rc = n_rc;
    end
  end

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
  endtask

  typedef struct {
    bit         rst_n;
    logic [3:0] dreq;
    logic [7:0] cmd;
    logic [3:0] mask;
    logic [3:0] rq;
    bit         idle;
    bit         vdack;
    bit         eop_n;
    logic [3:0] vd;
    bit         gv;
    logic [1:0] gc;
    logic [3:0] dack;
    logic [3:0] rc;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_gc;
    tbl[0]  = '{0, 4'h0, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 2'd0, 4'hF, 4'h0};
    tbl[1]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 2'd0, 4'hF, 4'h0};
    tbl[2]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h2, 0, 2'd0, 4'hF, 4'h0};
    tbl[3]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1, 2'd1, 4'hF, 4'h0};
    tbl[4]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 0, 1, 1, 4'h2, 1, 2'd1, 4'hD, 4'h0};
    tbl[5]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 0, 0, 1, 4'h2, 1, 2'd1, 4'hF, 4'h0};
    tbl[6]  = '{1, 4'hA, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[7]  = '{1, 4'h0, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h2, 0, 2'd1, 4'hF, 4'h0};
    tbl[8]  = '{1, 4'h0, 8'h00, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[9]  = '{1, 4'h3, 8'h00, 4'h1, 4'h0, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[10] = '{1, 4'h3, 8'h00, 4'h1, 4'h0, 1, 0, 1, 4'h2, 0, 2'd1, 4'hF, 4'h0};
    tbl[11] = '{1, 4'h3, 8'h04, 4'h1, 4'h8, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[12] = '{1, 4'h3, 8'h04, 4'h1, 4'h8, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[13] = '{1, 4'h0, 8'h00, 4'hF, 4'h8, 1, 0, 1, 4'h8, 0, 2'd1, 4'hF, 4'h0};
    tbl[14] = '{1, 4'h0, 8'h00, 4'hF, 4'h0, 1, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[15] = '{1, 4'h0, 8'h00, 4'hF, 4'h0, 0, 0, 1, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[16] = '{1, 4'h0, 8'h00, 4'hF, 4'h0, 0, 1, 0, 4'h0, 0, 2'd1, 4'hF, 4'h0};
    tbl[17] = '{1, 4'hB, 8'hC0, 4'h0, 4'h0, 1, 0, 1, 4'h1, 0, 2'd1, 4'h0, 4'h0};
    tbl[18] = '{1, 4'hB, 8'hC0, 4'h0, 4'h0, 1, 0, 1, 4'h4, 0, 2'd1, 4'h0, 4'h0};
    tbl[19] = '{1, 4'hB, 8'hC0, 4'h0, 4'h0, 0, 0, 1, 4'h4, 1, 2'd2, 4'h0, 4'h0};
    tbl[20] = '{1, 4'hB, 8'hC0, 4'h0, 4'h0, 0, 1, 1, 4'h4, 1, 2'd2, 4'h4, 4'h0};
    tbl[21] = '{1, 4'hB, 8'hC0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 2'd2, 4'h0, 4'h0};

    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      RESET_N    = tbl[i].rst_n;
      DREQ       = tbl[i].dreq;
      commandReg = tbl[i].cmd;
      maskReg    = tbl[i].mask;
      requestReg = tbl[i].rq;
      IDLE_CYCLE = tbl[i].idle;
      validDACK  = tbl[i].vdack;
      EOP_N      = tbl[i].eop_n;
      tick(1);
      check($sformatf("tbl%0d_vd", i), VALID_DREQ, tbl[i].vd);
      check($sformatf("tbl%0d_gv", i), grantValid, tbl[i].gv);
      check($sformatf("tbl%0d_gc", i), grantChannel, tbl[i].gc);
      check($sformatf("tbl%0d_dack", i), DACK, tbl[i].dack);
      check($sformatf("tbl%0d_rc", i), reqClear, tbl[i].rc);
    end

    // Rotating priority: five back-to-back services, order 0,1,2,3,0
    commandReg = 8'h10; DREQ = 4'hF; maskReg = '0; requestReg = '0;
    IDLE_CYCLE = 1; validDACK = 0; EOP_N = 1;
    do_reset();
    tick(2);
    check("rot_first_vd", VALID_DREQ, 4'b0001);
    for (int s = 0; s < 5; s++) begin
      exp_gc = s % 4;
      IDLE_CYCLE = 0;
      tick(1);
      check($sformatf("rot%0d_gv", s), grantValid, 1);
      check($sformatf("rot%0d_gc", s), grantChannel, 8'(exp_gc));
      tick(4);
      IDLE_CYCLE = 1;
      tick(1);
      check($sformatf("rot%0d_rel_gv", s), grantValid, 0);
      check($sformatf("rot%0d_bubble", s), VALID_DREQ, 0);
      tick(1);
      check($sformatf("rot%0d_next", s), VALID_DREQ,
            8'(1 << ((exp_gc + 1) % 4)));
    end

    // EOP-terminated software request clears its bit once
    commandReg = 8'h00; DREQ = '0; maskReg = 4'hF; requestReg = '0;
    IDLE_CYCLE = 1; EOP_N = 1; validDACK = 0;
    do_reset();
    requestReg = 4'b0100;
    tick(1);
    check("sw_latency", VALID_DREQ, 4'b0100);
    IDLE_CYCLE = 0;
    tick(1);
    check("eop_gc", grantChannel, 2);
    validDACK = 1;
    tick(1);
    validDACK = 0;
    tick(1);
    EOP_N = 0;
    tick(1);
    check("eop_no_early_rc", reqClear, 0);
    EOP_N = 1;
    tick(1);
    IDLE_CYCLE = 1;
    tick(1);
    check("eop_rc_pulse", reqClear, 4'b0100);
    requestReg = '0;
    tick(1);
    check("eop_rc_single", reqClear, 0);

    // Reset in the middle of a service
    commandReg = 8'h10; maskReg = '0; requestReg = '0; DREQ = 4'b0010;
    do_reset();
    tick(2);
    check("mid_vd", VALID_DREQ, 4'b0010);
    IDLE_CYCLE = 0;
    tick(5);
    IDLE_CYCLE = 1;
    DREQ = 4'hF;
    tick(1);
    tick(1);
    check("mid_rot_after1", VALID_DREQ, 4'b0100);
    IDLE_CYCLE = 0;
    tick(1);
    validDACK = 1;
    #1;
    check("mid_dack_on", DACK, 4'b1011);
    RESET_N = 0;
    tick(1);
    check("mid_rst_gv", grantValid, 0);
    check("mid_rst_dack", DACK, 4'hF);
    check("mid_rst_vd", VALID_DREQ, 0);
    RESET_N = 1; validDACK = 0; IDLE_CYCLE = 1;
    tick(2);
    check("mid_rst_lowpri", VALID_DREQ, 4'b0001);

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      check("rnd_vd", VALID_DREQ, m_vd);
      check("rnd_gv", grantValid, m_gv);
      check("rnd_gc", grantChannel, 8'(m_gc));
      check("rnd_dack", DACK, exp_dack());
      check("rnd_rc", reqClear, m_rc);
      RESET_N    = ($urandom_range(0, 199) != 0);
      DREQ       = 4'($urandom);
      commandReg = 8'($urandom) & 8'hD4;
      if ($urandom_range(0, 15) != 0) commandReg[2] = 1'b0;
      maskReg    = 4'($urandom);
      requestReg = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 3) == 0) IDLE_CYCLE = ~IDLE_CYCLE;
      validDACK  = 1'($urandom);
      EOP_N      = ($urandom_range(0, 9) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
